// File: rtl/xor_stream_pkg.sv
// Shared constants and helpers for the xor_gate_stream block.
// XOR_STREAM_BEATCNT_EN enables the beat counter in users of this package.
package xor_stream_pkg;

  typedef enum logic {
    STATE_IDLE  = 1'b0,
    STATE_ACCUM = 1'b1
  } state_e;

  localparam int unsigned BEAT_CNT_W = 8;
  localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = BEAT_CNT_W'(255);

  localparam int unsigned MODE_XOR    = 0;
  localparam int unsigned MODE_ONEHOT = 1;

  // Increment that sticks at BEAT_CNT_MAX instead of wrapping.
  function automatic logic [BEAT_CNT_W-1:0] sat_inc(input logic [BEAT_CNT_W-1:0] v);
    return (v == BEAT_CNT_MAX) ? v : v + BEAT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/xor_gate_stream_if.sv
// Input beat / output frame-result stream bundle for xor_gate_stream.
// out_beats exists only when XOR_STREAM_BEATCNT_EN is defined.
interface xor_gate_stream_if #(
  parameter int unsigned NR_OF_INPUTS = 2,
  parameter int unsigned WIDTH        = 8
);

  logic                          in_valid;
  logic                          in_ready;
  logic [NR_OF_INPUTS*WIDTH-1:0] in_data;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [WIDTH-1:0]              out_data;
`ifdef XOR_STREAM_BEATCNT_EN
  import xor_stream_pkg::*;
  logic [BEAT_CNT_W-1:0]         out_beats;
`endif

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
`ifdef XOR_STREAM_BEATCNT_EN
    , out_beats
`endif
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
`ifdef XOR_STREAM_BEATCNT_EN
    , out_beats
`endif
  );

endinterface

// File: rtl/xor_combine_bits.sv
// Per-bit-position bubble inversion and combine (odd parity or exactly-one-high)
// across NR_OF_INPUTS operand words; purely combinational.
module xor_combine_bits
  import xor_stream_pkg::*;
#(
  parameter int unsigned             NR_OF_INPUTS = 2,
  parameter int unsigned             WIDTH        = 8,
  parameter logic [NR_OF_INPUTS-1:0] BUBBLES_MASK = '0,
  parameter int unsigned             ONEHOT       = MODE_XOR
) (
  input  logic [NR_OF_INPUTS*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]              o_beat_c
);

  // Running parity, "any seen" and "more than one seen" chained per operand.
  for (genvar g = 0; g < NR_OF_INPUTS; g++) begin : g_in
    logic [WIDTH-1:0] w_op;
    logic [WIDTH-1:0] w_par;
    logic [WIDTH-1:0] w_any;
    logic [WIDTH-1:0] w_multi;

    assign w_op = i_data[g*WIDTH +: WIDTH] ^ {WIDTH{BUBBLES_MASK[g]}};

    if (g == 0) begin : g_first
      assign w_par   = w_op;
      assign w_any   = w_op;
      assign w_multi = '0;
    end else begin : g_next
      assign w_par   = g_in[g-1].w_par ^ w_op;
      assign w_any   = g_in[g-1].w_any | w_op;
      assign w_multi = g_in[g-1].w_multi | (g_in[g-1].w_any & w_op);
    end
  end

  if (ONEHOT == MODE_ONEHOT) begin : g_onehot
    assign o_beat_c = g_in[NR_OF_INPUTS-1].w_any & ~g_in[NR_OF_INPUTS-1].w_multi;
  end else begin : g_xor
    assign o_beat_c = g_in[NR_OF_INPUTS-1].w_par;
  end

endmodule

// File: rtl/xor_gate_stream.sv
// Streaming bubbled XOR / one-hot combiner with per-frame XOR accumulation.
// Define XOR_STREAM_BEATCNT_EN to add the saturating beat counter and out_beats.
module xor_gate_stream
  import xor_stream_pkg::*;
#(
  parameter int unsigned             NR_OF_INPUTS = 2,
  parameter int unsigned             WIDTH        = 8,
  parameter logic [NR_OF_INPUTS-1:0] BUBBLES_MASK = '0,
  parameter int unsigned             ONEHOT       = MODE_XOR
) (
  input logic              clock,
  input logic              reset_n,
  xor_gate_stream_if.slave bus
);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt, w_acc_base;
  logic             r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0] r_out_data, w_out_data_nxt;
  logic [WIDTH-1:0] w_beat;
  logic             w_in_ready_c;
  logic             w_accept;
`ifdef XOR_STREAM_BEATCNT_EN
  logic [BEAT_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [BEAT_CNT_W-1:0] r_out_beats, w_out_beats_nxt;
`endif

  xor_combine_bits #(
    .NR_OF_INPUTS (NR_OF_INPUTS),
    .WIDTH        (WIDTH),
    .BUBBLES_MASK (BUBBLES_MASK),
    .ONEHOT       (ONEHOT)
  ) u_combine (
    .i_data   (bus.in_data),
    .o_beat_c (w_beat)
  );

  // Stall everything while a result waits; allows take-and-reload in one cycle.
  assign w_in_ready_c  = !r_out_valid || bus.out_ready;
  assign w_accept      = bus.in_valid && w_in_ready_c;
  assign bus.in_ready  = w_in_ready_c;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
`ifdef XOR_STREAM_BEATCNT_EN
  assign bus.out_beats = r_out_beats;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= STATE_IDLE;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef XOR_STREAM_BEATCNT_EN
      r_cnt       <= '0;
      r_out_beats <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
`ifdef XOR_STREAM_BEATCNT_EN
      r_cnt       <= w_cnt_nxt;
      r_out_beats <= w_out_beats_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_acc_base      = (r_state == STATE_ACCUM) ? r_acc : '0;
`ifdef XOR_STREAM_BEATCNT_EN
    w_cnt_nxt       = r_cnt;
    w_out_beats_nxt = r_out_beats;
    w_cnt_inc       = sat_inc((r_state == STATE_ACCUM) ? r_cnt : '0);
`endif

    if (r_out_valid && bus.out_ready) begin
      w_out_valid_nxt = 1'b0;
    end

    if (w_accept) begin
      if (bus.in_last) begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = w_acc_base ^ w_beat;
        w_acc_nxt       = '0;
        w_state_nxt     = STATE_IDLE;
`ifdef XOR_STREAM_BEATCNT_EN
        w_out_beats_nxt = w_cnt_inc;
        w_cnt_nxt       = '0;
`endif
      end else begin
        w_acc_nxt       = w_acc_base ^ w_beat;
        w_state_nxt     = STATE_ACCUM;
`ifdef XOR_STREAM_BEATCNT_EN
        w_cnt_nxt       = w_cnt_inc;
`endif
      end
    end
  end

endmodule

// File: tb/tb_xor_gate_stream.sv
// Directed bench for xor_gate_stream: XOR and one-hot configurations, frames,
// backpressure, saturation and reset. out_beats checked with XOR_STREAM_BEATCNT_EN.
module tb_xor_gate_stream;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  xor_gate_stream_if #(.NR_OF_INPUTS(2), .WIDTH(8)) bus0 ();
  xor_gate_stream_if #(.NR_OF_INPUTS(3), .WIDTH(4)) bus1 ();
  xor_gate_stream_if #(.NR_OF_INPUTS(3), .WIDTH(4)) bus2 ();

  xor_gate_stream #(.NR_OF_INPUTS(2), .WIDTH(8), .BUBBLES_MASK(2'b00), .ONEHOT(0))
    u_dut0 (.clock(clk), .reset_n(rst_n), .bus(bus0));
  xor_gate_stream #(.NR_OF_INPUTS(3), .WIDTH(4), .BUBBLES_MASK(3'b000), .ONEHOT(1))
    u_oh (.clock(clk), .reset_n(rst_n), .bus(bus1));
  xor_gate_stream #(.NR_OF_INPUTS(3), .WIDTH(4), .BUBBLES_MASK(3'b100), .ONEHOT(1))
    u_ohb (.clock(clk), .reset_n(rst_n), .bus(bus2));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
    logic [7:0] exp_data;
    logic [7:0] exp_beats;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] a_s, b_s, exp_s;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one beat on bus0 and return one cycle after it is accepted.
  task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic last);
    int t = 0;
    bus0.in_valid = 1'b1;
    bus0.in_data  = {b, a};
    bus0.in_last  = last;
    #1;
    while (!bus0.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("send0_timeout", 8'(0), 8'(1));
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus0.in_last  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h0F, 8'h33, 1'b1, 8'h3C, 8'd1};
    vecs[1] = '{8'h01, 8'h00, 1'b0, 8'h00, 8'd0};
    vecs[2] = '{8'h00, 8'h02, 1'b0, 8'h00, 8'd0};
    vecs[3] = '{8'h04, 8'h00, 1'b1, 8'h07, 8'd3};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 8'd1};
    vecs[5] = '{8'hA5, 8'h0F, 1'b0, 8'h00, 8'd0};
    vecs[6] = '{8'h55, 8'h00, 1'b1, 8'hFF, 8'd2};
    vecs[7] = '{8'h80, 8'h01, 1'b1, 8'h81, 8'd1};
    vecs[8] = '{8'h3C, 8'h3C, 1'b0, 8'h00, 8'd0};
    vecs[9] = '{8'h12, 8'h10, 1'b1, 8'h02, 8'd2};

    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_last = 1'b0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_last = 1'b0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0; bus2.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_valid0", 8'(bus0.out_valid), 8'h00);
    check("rst_data0",  bus0.out_data, 8'h00);
    check("rst_ready0", 8'(bus0.in_ready), 8'h01);
    check("rst_valid1", 8'(bus1.out_valid), 8'h00);
    check("rst_data2",  8'(bus2.out_data), 8'h00);
`ifdef XOR_STREAM_BEATCNT_EN
    check("rst_beats0", bus0.out_beats, 8'h00);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back table of frames with out_ready held high
    for (int k = 0; k < 10; k++) begin
      send0(vecs[k].a, vecs[k].b, vecs[k].last);
      check($sformatf("vec%0d_valid", k), 8'(bus0.out_valid), 8'(vecs[k].last));
      if (vecs[k].last) begin
        check($sformatf("vec%0d_data", k), bus0.out_data, vecs[k].exp_data);
`ifdef XOR_STREAM_BEATCNT_EN
        check($sformatf("vec%0d_beats", k), bus0.out_beats, vecs[k].exp_beats);
`endif
      end
    end

    // One-hot combine, without and with bubble on operand 2
    bus1.in_data = {4'b0000, 4'b0101, 4'b0011};
    bus2.in_data = {4'b0000, 4'b0101, 4'b0011};
    bus1.in_valid = 1'b1; bus1.in_last = 1'b1;
    bus2.in_valid = 1'b1; bus2.in_last = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0; bus2.in_valid = 1'b0;
    check("oh_valid",  8'(bus1.out_valid), 8'h01);
    check("oh_data",   8'(bus1.out_data), 8'h06);
    check("ohb_valid", 8'(bus2.out_valid), 8'h01);
    check("ohb_data",  8'(bus2.out_data), 8'h08);
`ifdef XOR_STREAM_BEATCNT_EN
    check("oh_beats",  bus1.out_beats, 8'd1);
`endif
    @(posedge clk); #1;
    check("oh_drain",  8'(bus1.out_valid), 8'h00);

    // Backpressure: result held, input stalled, then same-cycle take and reload
    bus0.out_ready = 1'b0;
    send0(8'h12, 8'h34, 1'b1);
    check("bp_valid", 8'(bus0.out_valid), 8'h01);
    check("bp_data",  bus0.out_data, 8'h26);
    bus0.in_valid = 1'b1;
    bus0.in_data  = {8'h00, 8'h01};
    bus0.in_last  = 1'b1;
    #1;
    check("bp_ready", 8'(bus0.in_ready), 8'h00);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_data", c),  bus0.out_data, 8'h26);
      check($sformatf("stall%0d_valid", c), 8'(bus0.out_valid), 8'h01);
      check($sformatf("stall%0d_ready", c), 8'(bus0.in_ready), 8'h00);
    end
    bus0.out_ready = 1'b1;
    #1;
    check("reload_ready", 8'(bus0.in_ready), 8'h01);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus0.in_last  = 1'b0;
    check("reload_valid", 8'(bus0.out_valid), 8'h01);
    check("reload_data",  bus0.out_data, 8'h01);
`ifdef XOR_STREAM_BEATCNT_EN
    check("reload_beats", bus0.out_beats, 8'd1);
`endif
    @(posedge clk); #1;
    check("reload_drain", 8'(bus0.out_valid), 8'h00);

    // 300-beat frame: counter saturates, data is XOR of all beats
    exp_s = 8'h00;
    for (int k = 0; k < 300; k++) begin
      a_s   = 8'(k);
      b_s   = 8'(k * 7 + 3);
      exp_s = exp_s ^ a_s ^ b_s;
      send0(a_s, b_s, (k == 299));
    end
    check("sat_valid", 8'(bus0.out_valid), 8'h01);
    check("sat_data",  bus0.out_data, exp_s);
`ifdef XOR_STREAM_BEATCNT_EN
    check("sat_beats", bus0.out_beats, 8'd255);
`endif

    // Asynchronous reset while a result is held
    bus0.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 8'(bus0.out_valid), 8'h00);
    check("arst_data",  bus0.out_data, 8'h00);
    check("arst_ready", 8'(bus0.in_ready), 8'h01);
`ifdef XOR_STREAM_BEATCNT_EN
    check("arst_beats", bus0.out_beats, 8'h00);
`endif
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Mid-frame reset discards the partial accumulation
    bus0.out_ready = 1'b1;
    send0(8'h11, 8'h22, 1'b0);
    send0(8'h33, 8'h44, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", 8'(bus0.out_valid), 8'h00);
    check("mrst_data",  bus0.out_data, 8'h00);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send0(8'hAA, 8'h00, 1'b1);
    check("post_valid", 8'(bus0.out_valid), 8'h01);
    check("post_data",  bus0.out_data, 8'hAA);
`ifdef XOR_STREAM_BEATCNT_EN
    check("post_beats", bus0.out_beats, 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_gate_stream.md
# xor_gate_stream

Streaming, parametrised successor to the two-input bubbled XOR gate. Each accepted beat combines NR_OF_INPUTS words of WIDTH bits bit-position-wise, after per-input bubble inversion. The combine is either XOR (odd parity) or "exactly one high" (one-hot). Beat results are XOR-accumulated over a frame terminated by in_last, and the frame result is presented on a registered valid/ready output. It sits between the ALU flag logic and the bus-parity checker in the 6502 datapath.

## Interface
- NR_OF_INPUTS, 2: number of operand words per beat, range 2..8.
- WIDTH, 8: bits per operand word and per result.
- BUBBLES_MASK, 0: NR_OF_INPUTS-bit mask; bit i set inverts every bit of operand i before combining.
- ONEHOT, 0: 0 = XOR combine; 1 = per bit position, result is 1 iff exactly one operand bit is 1.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  NR_OF_INPUTS*WIDTH  operand i occupies bits [i*WIDTH +: WIDTH].
- in_last  in  1  final beat of the frame.
- out_valid  out  1  frame result held.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- out_data  out  WIDTH  frame result.
- out_beats  out  8  beats in the frame, saturating; present only with XOR_STREAM_BEATCNT_EN.

## Operation
- Beat result: b = combine over i of (operand_i ^ {WIDTH{BUBBLES_MASK[i]}}). Purely combinational from in_data.
- State IDLE (acc = 0, cnt = 0):
  - Accept without in_last: acc <= b, cnt <= 1, go to ACCUM.
  - Accept with in_last: go to the output-load path.
- State ACCUM:
  - Accept without in_last: acc <= acc ^ b, cnt <= sat(cnt+1).
  - Accept with in_last: go to the output-load path.
- Output load, on the accepting edge:
  - out_data <= acc ^ b, where acc is treated as 0 in IDLE.
  - out_beats <= sat(cnt+1).
  - out_valid <= 1.
  - acc <= 0, cnt <= 0, state <= IDLE.
- in_ready = !out_valid || out_ready. A new last beat may reload the output register in the same cycle the old result is taken.
- Output: out_valid clears on a take unless it is reloaded in the same cycle. out_data and out_beats remain stable while out_valid && !out_ready.
- Counter saturation: the count stops at 255 and never wraps.
- Reset (asynchronous, any time, including mid-frame): state IDLE, acc 0, cnt 0, out_valid 0, out_data 0, out_beats 0. A partially accumulated frame is discarded.

## Timing
- in_ready is combinational from out_valid and out_ready. There is no other input-to-output combinational path.
- Latency: out_valid rises on the clock edge that accepts the last beat, and is visible in the following cycle.
- Throughput: 1 beat per cycle sustained while out_ready = 1. A 1-beat frame every cycle is supported.
- Backpressure: when out_valid && !out_ready, in_ready = 0 and acc/cnt hold. Non-last beats are also stalled (simplest rule, no skid).

## Configuration
- XOR_STREAM_BEATCNT_EN defined: the cnt register, saturation logic and out_beats port are present.
- Not defined: cnt logic and the out_beats port are absent. All other behaviour is identical.

## Structure
- Shared package xor_stream_pkg holds:
  - the STATE_IDLE/STATE_ACCUM encoding;
  - BEAT_CNT_W = 8 and BEAT_CNT_MAX = 255;
  - the combine-mode constants MODE_XOR = 0 and MODE_ONEHOT = 1.
- One sub-module, xor_combine_bits, holds the purely combinational bubble-and-combine per bit position. It is instantiated once with a WIDTH-wide vector.

## Test plan
- XOR mode, NR_OF_INPUTS=2, BUBBLES_MASK=0: single last beat 0x0F, 0x33 -> next cycle out_valid=1, out_data=0x3C, out_beats=1.
- ONEHOT=1, NR_OF_INPUTS=3, WIDTH=4: operands 0b0011, 0b0101, 0b0000 as one last beat -> out_data=0b0110. With BUBBLES_MASK=0b100 the same operands -> out_data=0b1000.
- 3-beat frame, 2 inputs, beat results 0x01, 0x02, 0x04, out_ready=1 -> out_data=0x07, out_beats=3, acc returns to 0.
- Hold out_ready=0 with out_valid=1, then present a beat -> in_ready=0 and out_data stable for 5 cycles. Raise out_ready while a last beat is offered -> same-cycle take and reload, with out_valid staying 1.
- 300-beat frame -> out_beats=255 (saturated); out_data equals the XOR of all 300 beat results.
- Assert reset_n=0 asynchronously after 2 beats of a frame, then send 1 last beat 0xAA, 0x00 -> out_data=0xAA, out_beats=1. All outputs are 0 during reset.
